// File: rtl/backend_occupancy_tracker_if.sv
// Bundle of the dispatch, issue, commit and drain events observed by the
// occupancy tracker, plus the occupancy counts it reports back.
//   master : back-end event source (drives events, reads counts)
//   slave  : occupancy tracker (reads events, drives counts and error flag)
interface backend_occupancy_tracker_if #(
  parameter int unsigned DISPATCH_WIDTH  = 4,
  parameter int unsigned ISSUE_WIDTH     = 5,
  parameter int unsigned COMMIT_WIDTH    = 4,
  parameter int unsigned SIZE_ISSUEQ     = 32,
  parameter int unsigned SIZE_ACTIVELIST = 128,
  parameter int unsigned SIZE_LSQ        = 32
);
  localparam int unsigned IQ_LOG  = $clog2(SIZE_ISSUEQ);
  localparam int unsigned AL_LOG  = $clog2(SIZE_ACTIVELIST);
  localparam int unsigned LSQ_LOG = $clog2(SIZE_LSQ);

  logic                      recoverFlag_i;
  logic                      backEndReady_i;
  logic [DISPATCH_WIDTH-1:0] dispatchLaneActive_i;
  logic [DISPATCH_WIDTH-1:0] isLoad_i;
  logic [DISPATCH_WIDTH-1:0] isStore_i;
  logic [ISSUE_WIDTH-1:0]    iqIssued_i;
  logic [COMMIT_WIDTH-1:0]   commitValid_i;
  logic [COMMIT_WIDTH-1:0]   commitLoad_i;
  logic [COMMIT_WIDTH-1:0]   commitStore_i;
  logic                      storeDrain_i;
  logic [IQ_LOG:0]           issueQueueCnt_o;
  logic [AL_LOG:0]           activeListCnt_o;
  logic [LSQ_LOG:0]          loadQueueCnt_o;
  logic [LSQ_LOG:0]          storeQueueCnt_o;
  logic                      countError_o;

  modport master (
    output recoverFlag_i, backEndReady_i, dispatchLaneActive_i, isLoad_i, isStore_i,
           iqIssued_i, commitValid_i, commitLoad_i, commitStore_i, storeDrain_i,
    input  issueQueueCnt_o, activeListCnt_o, loadQueueCnt_o, storeQueueCnt_o, countError_o
  );

  modport slave (
    input  recoverFlag_i, backEndReady_i, dispatchLaneActive_i, isLoad_i, isStore_i,
           iqIssued_i, commitValid_i, commitLoad_i, commitStore_i, storeDrain_i,
    output issueQueueCnt_o, activeListCnt_o, loadQueueCnt_o, storeQueueCnt_o, countError_o
  );
endinterface

// File: rtl/backend_occupancy_tracker.sv
// Registered occupancy counters for the Issue Queue, Active List, Load Queue and
// Store Queue. Counts rise on accepted dispatch groups and fall on issue, commit
// and store drain. A flush zeroes IQ/AL/LQ while the SQ keeps its committed but
// not yet drained stores. Any clamp (underflow/overflow) sets a sticky error.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : event inputs and count outputs (slave side)
module backend_occupancy_tracker #(
  parameter int unsigned DISPATCH_WIDTH  = 4,
  parameter int unsigned ISSUE_WIDTH     = 5,
  parameter int unsigned COMMIT_WIDTH    = 4,
  parameter int unsigned SIZE_ISSUEQ     = 32,
  parameter int unsigned SIZE_ACTIVELIST = 128,
  parameter int unsigned SIZE_LSQ        = 32
) (
  input logic                           clk,
  input logic                           reset,
  backend_occupancy_tracker_if.slave    bus
);
  localparam int unsigned IQ_LOG  = $clog2(SIZE_ISSUEQ);
  localparam int unsigned AL_LOG  = $clog2(SIZE_ACTIVELIST);
  localparam int unsigned LSQ_LOG = $clog2(SIZE_LSQ);
  localparam int unsigned IqW     = IQ_LOG + 1;
  localparam int unsigned AlW     = AL_LOG + 1;
  localparam int unsigned LsqW    = LSQ_LOG + 1;

  logic [IQ_LOG:0]  iq_cnt_q, iq_cnt_d;
  logic [AL_LOG:0]  al_cnt_q, al_cnt_d;
  logic [LSQ_LOG:0] lq_cnt_q, lq_cnt_d;
  logic [LSQ_LOG:0] sq_cnt_q, sq_cnt_d;
  logic [LSQ_LOG:0] sq_committed_q, sq_committed_d;
  logic             err_q, err_d;

  // Saturate v into [0, hi]; e flags that saturation happened.
  function automatic int clamp(input int v, input int hi, output logic e);
    e = 1'b0;
    if (v < 0) begin
      e = 1'b1;
      return 0;
    end else if (v > hi) begin
      e = 1'b1;
      return hi;
    end
    return v;
  endfunction

  // Next values are formed in int, which is wider than the LOG+2 signed width
  // needed, so no intermediate sum can wrap before clamping.
  always_comb begin
    int   d_al, d_lq, d_sq, i_iq, c_al, c_lq, c_sq, drain;
    int   iq_n, al_n, lq_n, sq_n, sqc_n;
    logic e_iq, e_al, e_lq, e_sq, e_sqc;

    if (bus.backEndReady_i && !bus.recoverFlag_i) begin
      d_al = $countones(bus.dispatchLaneActive_i);
      d_lq = $countones(bus.dispatchLaneActive_i & bus.isLoad_i);
      d_sq = $countones(bus.dispatchLaneActive_i & bus.isStore_i);
    end else begin
      d_al = 0;
      d_lq = 0;
      d_sq = 0;
    end
    i_iq  = $countones(bus.iqIssued_i);
    c_al  = $countones(bus.commitValid_i);
    c_lq  = $countones(bus.commitValid_i & bus.commitLoad_i);
    c_sq  = $countones(bus.commitValid_i & bus.commitStore_i);
    drain = bus.storeDrain_i ? 1 : 0;

    // Committed-store count survives flushes; it becomes the SQ size on recovery.
    sqc_n = int'(sq_committed_q) + c_sq - drain;

    if (bus.recoverFlag_i) begin
      iq_n = 0;
      al_n = 0;
      lq_n = 0;
      sq_n = sqc_n;
    end else begin
      iq_n = int'(iq_cnt_q) + d_al - i_iq;
      al_n = int'(al_cnt_q) + d_al - c_al;
      lq_n = int'(lq_cnt_q) + d_lq - c_lq;
      sq_n = int'(sq_cnt_q) + d_sq - drain;
    end

    iq_n  = clamp(iq_n, int'(SIZE_ISSUEQ), e_iq);
    al_n  = clamp(al_n, int'(SIZE_ACTIVELIST), e_al);
    lq_n  = clamp(lq_n, int'(SIZE_LSQ), e_lq);
    sq_n  = clamp(sq_n, int'(SIZE_LSQ), e_sq);
    // Bounding by the new SQ count keeps sqCommitted <= SQ at all times.
    sqc_n = clamp(sqc_n, sq_n, e_sqc);

    iq_cnt_d       = IqW'(iq_n);
    al_cnt_d       = AlW'(al_n);
    lq_cnt_d       = LsqW'(lq_n);
    sq_cnt_d       = LsqW'(sq_n);
    sq_committed_d = LsqW'(sqc_n);
    err_d          = err_q | e_iq | e_al | e_lq | e_sq | e_sqc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iq_cnt_q       <= '0;
      al_cnt_q       <= '0;
      lq_cnt_q       <= '0;
      sq_cnt_q       <= '0;
      sq_committed_q <= '0;
      err_q          <= 1'b0;
    end else begin
      iq_cnt_q       <= iq_cnt_d;
      al_cnt_q       <= al_cnt_d;
      lq_cnt_q       <= lq_cnt_d;
      sq_cnt_q       <= sq_cnt_d;
      sq_committed_q <= sq_committed_d;
      err_q          <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (sq_committed_q <= sq_cnt_q)
        else $error("sqCommitted exceeds store queue occupancy");
    end
  end

  assign bus.issueQueueCnt_o = iq_cnt_q;
  assign bus.activeListCnt_o = al_cnt_q;
  assign bus.loadQueueCnt_o  = lq_cnt_q;
  assign bus.storeQueueCnt_o = sq_cnt_q;
  assign bus.countError_o    = err_q;
endmodule
